// File: rtl/tap_sum_pkg.sv
// Shared widths, types and the tap multiply helper for the tap_sum_pipe block.
package tap_sum_pkg;

    localparam int TAP_N      = 4;
    localparam int DATA_W     = 8;
    localparam int COEF_W     = 8;
    localparam int PROD_W     = 17;
    localparam int PSUM_W     = 18;
    localparam int FULL_W     = 19;
    localparam int FILL_DEPTH = 64;
    localparam int FILL_W     = 7;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [PSUM_W-1:0] psum_t;
    typedef logic signed [FULL_W-1:0] full_t;

    // Unsigned tap times signed coefficient; 9-bit x 8-bit signed always fits in 17 bits.
    function automatic prod_t tap_mul(input logic [DATA_W-1:0] tap, input coef_t c);
        prod_t a;
        prod_t b;
        a = prod_t'({1'b0, tap});
        b = prod_t'(c);
        return a * b;
    endfunction

endpackage

// File: rtl/tap_sum_tree.sv
// Registered stage-2/stage-3 adder tree with valid pipeline and output resize.
// Build option: define SUM_SAT_EN to clamp the sum to OUT_W bits instead of wrapping.
module tap_sum_tree
    import tap_sum_pkg::*;
#(
    parameter int OUT_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               v1,
    input  prod_t              prod [TAP_N],
    output logic signed [OUT_W-1:0] sum,
    output logic               sum_valid,
    output logic               sat
);

    psum_t psum [2];
    full_t full;
    logic  v2;
    logic  clip;
    logic signed [OUT_W-1:0] sum_next;

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (v1) begin
            psum[0] <= psum_t'(prod[0]) + psum_t'(prod[1]);
            psum[1] <= psum_t'(prod[2]) + psum_t'(prod[3]);
        end
    end

    assign full = full_t'(psum[0]) + full_t'(psum[1]);

`ifdef SUM_SAT_EN
    localparam full_t SUM_MAX = full_t'((2 ** (OUT_W - 1)) - 1);
    localparam full_t SUM_MIN = full_t'(-(2 ** (OUT_W - 1)));

    always_comb begin
        clip     = 1'b0;
        sum_next = full[OUT_W-1:0];
        if (full > SUM_MAX) begin
            clip     = 1'b1;
            sum_next = SUM_MAX[OUT_W-1:0];
        end else if (full < SUM_MIN) begin
            clip     = 1'b1;
            sum_next = SUM_MIN[OUT_W-1:0];
        end
    end
`else
    assign clip     = 1'b0;
    assign sum_next = full[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v2        <= 1'b0;
            sum_valid <= 1'b0;
            sat       <= 1'b0;
            sum       <= '0;
        end else begin
            v2        <= v1;
            sum_valid <= v2;
            sat       <= v2 & clip;
            if (v2) begin
                sum <= sum_next;
            end
        end
    end

endmodule

// File: rtl/tap_sum_pipe.sv
// Weighted sum of the four taps of the 8x64 line, one result per primed shift.
// Build option: SUM_SAT_EN selects clamping (with sat flag) instead of wrapping.
module tap_sum_pipe
    import tap_sum_pkg::*;
#(
    parameter coef_t COEF0 = 8'sd1,
    parameter coef_t COEF1 = 8'sd1,
    parameter coef_t COEF2 = 8'sd1,
    parameter coef_t COEF3 = 8'sd1,
    parameter int    OUT_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic [7:0]         tap_one,
    input  logic [7:0]         tap_two,
    input  logic [7:0]         tap_three,
    input  logic [7:0]         tap_out,
    input  logic               coef_wr,
    input  logic [1:0]         coef_addr,
    input  logic [7:0]         coef_data,
    output logic signed [OUT_W-1:0] sum,
    output logic               sum_valid,
    output logic               filled,
    output logic               sat
);

    logic [FILL_W-1:0] fill_cnt;
    logic              shift_d;
    logic              primed_d;
    logic              v1;
    coef_t             coef [TAP_N];
    prod_t             prod [TAP_N];
    logic [DATA_W-1:0] taps [TAP_N];

    assign taps   = '{tap_one, tap_two, tap_three, tap_out};
    assign filled = (fill_cnt == FILL_W'(FILL_DEPTH));

    // The line's taps settle one cycle after shift, so capture is keyed off shift_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_d  <= 1'b0;
            primed_d <= 1'b0;
            v1       <= 1'b0;
            fill_cnt <= '0;
            coef[0]  <= COEF0;
            coef[1]  <= COEF1;
            coef[2]  <= COEF2;
            coef[3]  <= COEF3;
        end else begin
            shift_d  <= shift;
            primed_d <= shift && (fill_cnt >= FILL_W'(FILL_DEPTH - 1));
            v1       <= shift_d & primed_d;
            if (shift && !filled) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
            end
            if (coef_wr) begin
                coef[coef_addr] <= coef_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shift_d) begin
            for (int i = 0; i < TAP_N; i++) begin
                prod[i] <= tap_mul(taps[i], coef[i]);
            end
        end
    end

    tap_sum_tree #(
        .OUT_W(OUT_W)
    ) u_tree (
        .clk      (clk),
        .rst      (rst),
        .v1       (v1),
        .prod     (prod),
        .sum      (sum),
        .sum_valid(sum_valid),
        .sat      (sat)
    );

endmodule

// File: tb/tb_tap_sum_pipe.sv
// Self-checking bench for tap_sum_pipe: table vectors, corner sequences and a
// queue-based reference model fed from a history of shifted-in samples.
module tb_tap_sum_pipe;
    import tap_sum_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, shift, coef_wr;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data, din;
    logic [63:0][7:0] line = '0;
    logic [7:0]  tap_one, tap_two, tap_three, tap_out;
    logic signed [18:0] sum;
    logic        sum_valid, filled, sat;

    logic        rst_s, shift_s;
    logic signed [11:0] sum_s;
    logic        sum_valid_s, filled_s, sat_s;

    // Upstream 8x64 shift register: taps move one cycle after shift.
    always @(posedge clk) if (shift) line <= {line[62:0], din};
    assign tap_one   = line[15];
    assign tap_two   = line[31];
    assign tap_three = line[47];
    assign tap_out   = line[63];

    tap_sum_pipe dut (
        .clk(clk), .rst(rst), .shift(shift),
        .tap_one(tap_one), .tap_two(tap_two), .tap_three(tap_three), .tap_out(tap_out),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .sum(sum), .sum_valid(sum_valid), .filled(filled), .sat(sat)
    );

    tap_sum_pipe #(
        .COEF0(-8'sd128), .COEF1(-8'sd128), .COEF2(-8'sd128), .COEF3(-8'sd128), .OUT_W(12)
    ) dut_s (
        .clk(clk), .rst(rst_s), .shift(shift_s),
        .tap_one(8'hFF), .tap_two(8'hFF), .tap_three(8'hFF), .tap_out(8'hFF),
        .coef_wr(1'b0), .coef_addr(2'd0), .coef_data(8'd0),
        .sum(sum_s), .sum_valid(sum_valid_s), .filled(filled_s), .sat(sat_s)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int valid_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: sample history (index 0 = newest), coefficients, pending results.
    typedef struct { int due; int val; } exp_t;
    int   m_coef [4];
    int   hist [$];
    int   n_since_rst;
    exp_t exp_q [$];

    function automatic int model_sum();
        int s = 0;
        for (int k = 0; k < 4; k++) s += m_coef[k] * hist[15 + 16 * k];
        return s;
    endfunction

    always @(negedge clk) begin
        bit ev;
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (sum_valid) valid_seen++;
        if (sum_valid || ev) begin
            check("valid_timing", int'(sum_valid), int'(ev));
            if (ev) begin
                if (sum_valid) check("model_sum", int'(sum), exp_q[0].val);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_cycle(input bit sh, input logic [7:0] d, input bit wr = 1'b0,
                            input logic [1:0] a = 2'd0, input logic [7:0] cd = 8'd0);
        shift = sh; din = d; coef_wr = wr; coef_addr = a; coef_data = cd;
        @(posedge clk);
        #1;
        if (sh) begin
            hist.push_front(int'(d));
            if (hist.size() > 64) void'(hist.pop_back());
        end
        if (rst) begin
            exp_q.delete();
            n_since_rst = 0;
            m_coef = '{1, 1, 1, 1};
        end else begin
            if (wr) m_coef[a] = int'($signed(cd));
            if (sh) begin
                n_since_rst++;
                if (n_since_rst >= 64) exp_q.push_back('{due: cyc + 3, val: model_sum()});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, 8'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        do_cycle(1'b0, 8'd0);
        rst = 1'b0;
    endtask

    task automatic wr_coefs(input int c [4]);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 8'd0, 1'b1, 2'(i), 8'(c[i]));
    endtask

    typedef struct { int c [4]; int base; int step; int exp_sum; } vec_t;
    vec_t vecs [6];

    initial begin
        int vs0, exp_v;
        vecs[0] = '{c: '{1, 1, 1, 1},         base: 10,  step: 0, exp_sum: 40};
        vecs[1] = '{c: '{1, 2, 3, 4},         base: 0,   step: 1, exp_sum: 160};
        vecs[2] = '{c: '{-1, -1, -1, -1},     base: 255, step: 0, exp_sum: -1020};
        vecs[3] = '{c: '{127, 127, 127, 127}, base: 255, step: 0, exp_sum: 129540};
        vecs[4] = '{c: '{-128, -128, -128, -128}, base: 255, step: 0, exp_sum: -130560};
        vecs[5] = '{c: '{2, -3, 5, -7},       base: 0,   step: 3, exp_sum: 240};

        for (int i = 0; i < 64; i++) hist.push_back(0);
        m_coef = '{1, 1, 1, 1};
        n_since_rst = 0;
        rst = 1'b1; rst_s = 1'b1; shift_s = 1'b0;
        shift = 1'b0; din = '0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        do_cycle(1'b0, 8'd0);
        do_cycle(1'b0, 8'd0);
        rst = 1'b0; rst_s = 1'b0;

        check("rst_sum", int'(sum), 0);
        check("rst_sum_valid", int'(sum_valid), 0);
        check("rst_filled", int'(filled), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_sum_s", int'(sum_s), 0);
        check("rst_sat_s", int'(sat_s), 0);
        shift_s = 1'b1;

        // Table vectors: fresh fill from reset, then check the 64th-shift result.
        for (int v = 0; v < 6; v++) begin
            apply_reset();
            wr_coefs(vecs[v].c);
            vs0 = valid_seen;
            for (int i = 0; i < 64; i++) begin
                if (i == 63) begin
                    check("filled_before_64", int'(filled), 0);
                    check("no_valid_unprimed", valid_seen - vs0, 0);
                end
                do_cycle(1'b1, 8'((vecs[v].base + vecs[v].step * i) & 255));
            end
            check("filled_after_64", int'(filled), 1);
            idle(5);
            check("vec_sum", int'(sum), vecs[v].exp_sum);
            check("vec_one_valid", valid_seen - vs0, 1);
            check("vec_sum_hold", int'(sum_valid), 0);
        end

        // Coefficient write racing the capture cycle of a shift.
        wr_coefs('{1, 1, 1, 1});
        do_cycle(1'b1, 8'd20);
        do_cycle(1'b0, 8'd0, 1'b1, 2'd0, 8'd5);
        do_cycle(1'b1, 8'd30);
        exp_v = 5 * hist[15] + hist[31] + hist[47] + hist[63];
        idle(5);
        check("race_new_coef_sum", int'(sum), exp_v);

        // Continuous shifting with random data and occasional random coefficient writes.
        vs0 = valid_seen;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_cycle(1'b1, 8'($urandom), 1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
            else
                do_cycle(1'b1, 8'($urandom));
        end
        idle(5);
        check("continuous_valids", valid_seen - vs0, 80);
        check("sat_main", int'(sat), 0);

        // Reset with three results in flight.
        wr_coefs('{7, -9, 3, 2});
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 8'($urandom));
        vs0 = valid_seen;
        apply_reset();
        check("midrst_filled", int'(filled), 0);
        idle(4);
        check("midrst_squash", valid_seen - vs0, 0);
        for (int i = 0; i < 63; i++) do_cycle(1'b1, 8'($urandom));
        idle(5);
        check("midrst_no_early_valid", valid_seen - vs0, 0);
        do_cycle(1'b1, 8'($urandom));
        exp_v = hist[15] + hist[31] + hist[47] + hist[63];
        idle(5);
        check("midrst_refill_valid", valid_seen - vs0, 1);
        check("midrst_param_coef_sum", int'(sum), exp_v);

        // Narrow instance: all-max taps times -128 overflows 12 bits.
        check("narrow_valid", int'(sum_valid_s), 1);
        check("narrow_filled", int'(filled_s), 1);
`ifdef SUM_SAT_EN
        check("narrow_sum", int'(sum_s), -2048);
        check("narrow_sat", int'(sat_s), 1);
`else
        check("narrow_sum", int'(sum_s), 512);
        check("narrow_sat", int'(sat_s), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
